minifloat_accum: RTL
====================

Name: minifloat_accum

Overview:
- Streaming consumer placed directly downstream of the integer-to-minifloat converter.
- Accepts 7-bit unsigned minifloat codes (3-bit exponent, 4-bit mantissa) over a valid/ready handshake and decodes each code back to an integer.
- Accumulates the decoded values into a saturating sum.
- Emits one {sum, count, saturated} result per block. A block ends when a flush request arrives or when BLOCK_LEN elements have been accepted.

Parameters:
ACC_W, 16, accumulator/output sum width (min 11)
CNT_W, 8, element counter width; must satisfy BLOCK_LEN <= 2^CNT_W-1
BLOCK_LEN, 16, elements per block before auto-emit (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input code valid
in_ready  out  1  block can accept a code
in_data  in  7  minifloat code: [6:4]=exponent e, [3:0]=mantissa m
flush  in  1  end current block (level sampled each cycle)
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_sum  out  ACC_W  saturated sum of decoded values in the block
out_count  out  CNT_W  number of elements in the block
out_sat  out  1  sum saturated at least once in the block

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Decode rule:
  - e==0: value = m.
  - e>0: value = {1,m} << (e-1).
  - Range is 0..1984 (code 0x7F), carried as an 11-bit unsigned value.
- Accept: a transfer occurs on any rising edge where in_valid && in_ready.
- Pipeline:
  - Stage 1 registers the decoded value plus valid bit v1, one cycle after accept.
  - Stage 2 adds it to sum on the next edge: sum <= min(sum+val, 2^ACC_W-1), and count <= count+1.
  - If the clamp engages, sat <= 1 (sticky until the block is cleared).
- FSM states ACC, DRAIN, OUT. Reset enters ACC with sum=0, count=0, sat=0, v1=0.
- ACC state:
  - in_ready=1.
  - End-of-block trigger is either (a) flush==1 on an edge, or (b) a transfer that is the BLOCK_LEN-th accepted element of the block.
  - On trigger, go to DRAIN. A transfer on the same edge as flush is included in the block.
- DRAIN state: in_ready=0. Lasts exactly one cycle while stage 1 retires into stage 2, then go to OUT.
- OUT state:
  - out_valid=1; out_sum, out_count and out_sat are stable, and in_ready=0.
  - On out_valid && out_ready, clear sum, count and sat, and go to ACC; in_ready=1 in the next cycle.
- Latency: last transfer on the edge ending cycle N gives out_valid=1 in cycle N+2. A flush in ACC with no transfer that cycle also gives out_valid in cycle N+2.
- Empty block: a flush with no prior elements emits sum=0, count=0, sat=0.
- flush is ignored in DRAIN and OUT. It is not queued.
- in_data is don't-care when no transfer occurs. No element is lost or double-counted under arbitrary in_valid/out_ready patterns.
- Outputs are registered or pure functions of FSM state. There is no combinational path from in_valid or out_ready to any output except through state.
- Reset values: in_ready=0 while rst==1 and 1 in the first cycle after rst deasserts. out_valid=0, out_sum=0, out_count=0, out_sat=0.
- Reset mid-operation (any state, including DRAIN/OUT with out_valid high) discards the pipeline and partial sum. No result is emitted.

Test Plan:
- Decode/sum: codes 0x00, 0x0F, 0x10, 0x1F, 0x7F accepted back-to-back, then flush=1 for one cycle after the last transfer.
  - Required: out_sum=2046, out_count=5, out_sat=0, out_valid two cycles after the flush edge.
- Auto-emit (BLOCK_LEN=4): four transfers of 0x25 (value 42) with flush held low.
  - Required: in_ready falls the cycle after the 4th transfer; out_sum=168, out_count=4.
  - A 5th code presented in that window is accepted only after the out handshake and starts a new block.
- Saturation (ACC_W=12): three transfers of 0x7F, then flush.
  - Required: out_sum=4095, out_count=3, out_sat=1.
  - The next block of one 0x01 plus flush gives sum=1, sat=0.
- Backpressure: out_ready=0 for 5 cycles in OUT.
  - Required: out_* stable, in_ready=0, a held in_valid not accepted; results emitted once on out_ready=1.
- Flush corners:
  - Flush with an empty block gives sum=0, count=0.
  - Flush on the same edge as a transfer of 0x12 (value 18) gives sum=18, count=1.
  - Flush asserted during OUT is ignored, and no extra result appears.
- Reset: rst=1 for one cycle after 3 transfers (and again while out_valid=1).
  - Required: out_valid=0 and no result emitted.
  - The following block of 0x08 plus flush gives sum=8, count=1.

Source files
------------

// File: rtl/minifloat_accum.sv
// rtl/minifloat_accum.sv - decodes 7-bit minifloat codes and emits saturating per-block sums
module minifloat_accum #(
    parameter int ACC_W     = 16,
    parameter int CNT_W     = 8,
    parameter int BLOCK_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] SUM_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

    state_t           state;
    state_t           state_nx;
    logic [10:0]      dec_val;
    logic [10:0]      val1;
    logic             v1;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] taken;
    logic             sat;
    logic [ACC_W:0]   sum_ext;
    logic             xfer;
    logic             done;

    assign xfer = in_valid && in_ready;
    assign done = out_valid && out_ready;

    always_comb begin
        dec_val = {7'd0, in_data[3:0]};
        if (in_data[6:4] != 3'd0) begin
            dec_val = {6'd0, 1'b1, in_data[3:0]} << (in_data[6:4] - 3'd1);
        end
    end

    // Extra top bit catches overflow so the clamp can be applied in one step.
    assign sum_ext = {1'b0, sum} + {{(ACC_W - 10){1'b0}}, val1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACC: begin
                if (flush || (xfer && (taken == LAST_IDX))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN:   state_nx = OUT;
            OUT: begin
                if (out_ready) begin
                    state_nx = ACC;
                end
            end
            default: state_nx = ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACC) && !rst;
        out_valid = (state == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            val1  <= '0;
            sum   <= '0;
            count <= '0;
            sat   <= 1'b0;
            taken <= '0;
        end else begin
            v1 <= xfer;
            if (xfer) begin
                val1  <= dec_val;
                taken <= taken + 1'b1;
            end
            if (done) begin
                sum   <= '0;
                count <= '0;
                sat   <= 1'b0;
                taken <= '0;
            end else if (v1) begin
                if (sum_ext[ACC_W]) begin
                    sum <= SUM_MAX;
                    sat <= 1'b1;
                end else begin
                    sum <= sum_ext[ACC_W-1:0];
                end
                count <= count + 1'b1;
            end
        end
    end

    assign out_sum   = sum;
    assign out_count = count;
    assign out_sat   = sat;

endmodule
